// File: rtl/replay_pkg.sv
// Shared types and helpers for the data-link replay scheduler.
// Holds the sequence width, DLLP type codes, FSM states and modulo difference.
package replay_pkg;

    localparam int SEQ_W = 12;

    localparam logic [1:0] ACK = 2'b01;
    localparam logic [1:0] NAK = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REPLAY  = 2'd1,
        RETRAIN = 2'd2
    } state_t;

    // Distance from b forward to a, modulo 2^SEQ_W.
    function automatic logic [SEQ_W-1:0] seq_diff(
        input logic [SEQ_W-1:0] a,
        input logic [SEQ_W-1:0] b
    );
        return a - b;
    endfunction

endpackage

// File: rtl/replay_timer.sv
// Replay timer: counts enabled cycles and pulses expire on the TIMEOUT-th.
// Ports: clk, rst, clear (to zero), hold (freeze), en (count), expire (pulse).
module replay_timer #(
    parameter int TIMEOUT = 1024,
    parameter int TMR_W   = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    input  logic en,
    output logic expire
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] count;

    assign expire = en & ~clear & ~hold & (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (hold) begin
            count <= count;
        end else if (en) begin
            count <= expire ? '0 : count + TMR_W'(1);
        end
    end

endmodule

// File: rtl/replay_scheduler.sv
// Replay buffer sequencer: grants TLP sequence numbers, applies ACK/NAK,
// purges acknowledged entries, drives replay reads and requests retrain.
// Ports: tlp_req/gnt/seq (source), dllp_* (ACK/NAK in), buf_ready/rd_en/
// rd_idx (replay read), purge_valid/seq, replay_active/num, retrain_req/done,
// full.
module replay_scheduler #(
    parameter int SEQ_W   = 12,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    parameter int TMR_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tlp_req,
    output logic             tlp_gnt,
    output logic [SEQ_W-1:0] tlp_seq,
    input  logic             dllp_valid,
    input  logic [1:0]       dllp_type,
    input  logic [SEQ_W-1:0] dllp_seq,
    input  logic             buf_ready,
    output logic             rd_en,
    output logic [SEQ_W-1:0] rd_idx,
    output logic             purge_valid,
    output logic [SEQ_W-1:0] purge_seq,
    output logic             replay_active,
    output logic [1:0]       replay_num,
    output logic             retrain_req,
    input  logic             retrain_done,
    output logic             full
);
    import replay_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [SEQ_W-1:0] nts;
    logic [SEQ_W-1:0] ackd;
    logic [SEQ_W-1:0] outstanding;
    logic [SEQ_W-1:0] d;
    logic [SEQ_W-1:0] new_ackd;
    logic [SEQ_W-1:0] rd_adv;
    logic [SEQ_W-1:0] rd_next;
    logic [SEQ_W-1:0] ack_next;
    logic [1:0]       rn_eff;
    logic             pending;
    logic             has_out;
    logic             dllp_ok;
    logic             fwd;
    logic             nak_hit;
    logic             expire;

    assign outstanding = seq_diff(nts, ackd) - SEQ_W'(1);
    assign has_out     = outstanding != '0;
    assign full        = outstanding == SEQ_W'(DEPTH);
    assign tlp_seq     = nts;
    assign purge_seq   = ackd;

    // A DLLP is only honoured if it names an outstanding or the last
    // acknowledged sequence number; anything else is stale.
    assign d       = seq_diff(dllp_seq, ackd);
    assign dllp_ok = dllp_valid
                   & (dllp_type == ACK | dllp_type == NAK)
                   & (d <= outstanding);
    assign fwd      = dllp_ok & (d != '0);
    assign nak_hit  = dllp_ok & (dllp_type == NAK);
    assign new_ackd = fwd ? dllp_seq : ackd;
    assign rn_eff   = fwd ? 2'd0 : replay_num;
    assign ack_next = dllp_seq + SEQ_W'(1);

    // Next replay index: advance on a read, then skip past anything a
    // forward-progress ACK just retired (ordered relative to ACKD_SEQ).
    assign rd_adv  = rd_en ? rd_idx + SEQ_W'(1) : rd_idx;
    assign rd_next = (fwd && seq_diff(ack_next, ackd) > seq_diff(rd_adv, ackd))
                   ? ack_next : rd_adv;

    replay_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (~has_out | fwd),
        .hold   (state != IDLE),
        .en     (has_out & (state == IDLE)),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pending && has_out) begin
                    state_nxt = (rn_eff == 2'd3) ? RETRAIN : REPLAY;
                end
            end
            REPLAY: begin
                if (rd_next == nts) begin
                    state_nxt = IDLE;
                end
            end
            RETRAIN: begin
                if (retrain_done) begin
                    state_nxt = REPLAY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tlp_gnt       = tlp_req & ~full & (state == IDLE) & ~pending;
        rd_en         = (state == REPLAY) & buf_ready & (rd_idx != nts);
        replay_active = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nts         <= '0;
            ackd        <= '1;
            rd_idx      <= '0;
            pending     <= 1'b0;
            purge_valid <= 1'b0;
            retrain_req <= 1'b0;
            replay_num  <= 2'd0;
        end else begin
            nts         <= tlp_gnt ? nts + SEQ_W'(1) : nts;
            ackd        <= new_ackd;
            purge_valid <= fwd;
            retrain_req <= (state == IDLE) && (state_nxt == RETRAIN);
            // Pending is always consumed in IDLE; new NAKs or expiry re-arm it.
            pending     <= (pending & (state != IDLE)) | nak_hit | expire;

            replay_num <= rn_eff;
            if (state == IDLE && state_nxt == REPLAY) begin
                replay_num <= rn_eff + 2'd1;
            end else if (state == IDLE && state_nxt == RETRAIN) begin
                replay_num <= 2'd0;
            end else if (state == RETRAIN && state_nxt == REPLAY) begin
                replay_num <= 2'd1;
            end

            if (state != REPLAY && state_nxt == REPLAY) begin
                rd_idx <= new_ackd + SEQ_W'(1);
            end else if (state == REPLAY) begin
                rd_idx <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_replay_scheduler.sv
// Bench for replay_scheduler: directed scenarios plus random traffic,
// each cycle compared against a behavioural sequence-number model.
module tb_replay_scheduler;

    localparam int DEPTH = 16;
    localparam int TMO   = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        tlp_req;
    logic        tlp_gnt;
    logic [11:0] tlp_seq;
    logic        dllp_valid;
    logic [1:0]  dllp_type;
    logic [11:0] dllp_seq;
    logic        buf_ready;
    logic        rd_en;
    logic [11:0] rd_idx;
    logic        purge_valid;
    logic [11:0] purge_seq;
    logic        replay_active;
    logic [1:0]  replay_num;
    logic        retrain_req;
    logic        retrain_done;
    logic        full;

    always #5 clk = ~clk;

    replay_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .tlp_req       (tlp_req),
        .tlp_gnt       (tlp_gnt),
        .tlp_seq       (tlp_seq),
        .dllp_valid    (dllp_valid),
        .dllp_type     (dllp_type),
        .dllp_seq      (dllp_seq),
        .buf_ready     (buf_ready),
        .rd_en         (rd_en),
        .rd_idx        (rd_idx),
        .purge_valid   (purge_valid),
        .purge_seq     (purge_seq),
        .replay_active (replay_active),
        .replay_num    (replay_num),
        .retrain_req   (retrain_req),
        .retrain_done  (retrain_done),
        .full          (full)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model: link state as plain integers (mode 0 idle, 1 replaying, 2 retrain)
    int m_nts, m_ackd, m_mode, m_pend, m_rnum, m_rdi, m_tmr, m_pv, m_rr;
    int s_gnt, s_seq, s_full, s_rd_en, s_rd_idx, s_pv, s_ps, s_act, s_rn, s_rr;

    function automatic int wrap(input int x);
        return x & 4095;
    endfunction

    function automatic int m_out();
        return wrap(m_nts - m_ackd - 1);
    endfunction

    task automatic m_reset();
        m_nts = 0; m_ackd = 4095; m_mode = 0; m_pend = 0; m_rnum = 0;
        m_rdi = 0; m_tmr = 0; m_pv = 0; m_rr = 0;
    endtask

    task automatic m_next(input int eg, input int erd);
        int o, ds, dd, ok, fwd, nak, nack, ex, rne, nxt, pn;
        if (rst) begin
            m_reset();
            return;
        end
        o    = m_out();
        ds   = int'(dllp_seq);
        dd   = wrap(ds - m_ackd);
        ok   = dllp_valid && (dllp_type == 2'b01 || dllp_type == 2'b10) && dd <= o;
        fwd  = ok && dd > 0;
        nak  = ok && dllp_type == 2'b10;
        nack = fwd ? ds : m_ackd;
        ex   = 0;
        if (o == 0 || fwd) m_tmr = 0;
        else if (m_mode == 0) begin
            if (m_tmr == TMO - 1) begin ex = 1; m_tmr = 0; end
            else m_tmr++;
        end
        rne    = fwd ? 0 : m_rnum;
        m_rnum = rne;
        m_rr   = 0;
        pn     = nak || ex;
        case (m_mode)
            0: if (m_pend && o > 0) begin
                if (rne == 3) begin
                    m_mode = 2; m_rr = 1; m_rnum = 0;
                end else begin
                    m_mode = 1; m_rnum = rne + 1; m_rdi = wrap(nack + 1);
                end
            end
            1: begin
                pn  = pn || m_pend;
                nxt = wrap(m_rdi + erd);
                if (fwd && wrap(ds + 1 - m_ackd) > wrap(nxt - m_ackd))
                    nxt = wrap(ds + 1);
                m_rdi = nxt;
                if (m_rdi == m_nts) m_mode = 0;
            end
            default: begin
                pn = pn || m_pend;
                if (retrain_done) begin
                    m_mode = 1; m_rnum = 1; m_rdi = wrap(nack + 1);
                end
            end
        endcase
        m_pend = pn;
        m_nts  = wrap(m_nts + eg);
        m_ackd = nack;
        m_pv   = fwd;
    endtask

    task automatic step();
        int o, eg, erd;
        @(negedge clk);
        o   = m_out();
        eg  = tlp_req && o != DEPTH && m_mode == 0 && !m_pend;
        erd = m_mode == 1 && buf_ready && m_rdi != m_nts;
        s_gnt = tlp_gnt; s_seq = tlp_seq; s_full = full; s_rd_en = rd_en;
        s_rd_idx = rd_idx; s_pv = purge_valid; s_ps = purge_seq;
        s_act = replay_active; s_rn = replay_num; s_rr = retrain_req;
        check("tlp_gnt", s_gnt, eg);
        check("tlp_seq", s_seq, m_nts);
        check("full", s_full, o == DEPTH);
        check("rd_en", s_rd_en, erd);
        check("rd_idx", s_rd_idx, m_rdi);
        check("purge_valid", s_pv, m_pv);
        check("purge_seq", s_ps, m_ackd);
        check("replay_active", s_act, m_mode != 0);
        check("replay_num", s_rn, m_rnum);
        check("retrain_req", s_rr, m_rr);
        m_next(eg, erd);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; tlp_req = 0; dllp_valid = 0; dllp_type = 0; dllp_seq = 0;
        buf_ready = 1; retrain_done = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic send_tlps(input int n);
        tlp_req = 1;
        repeat (n) step();
        tlp_req = 0;
    endtask

    task automatic send_dllp(input int t, input int s);
        dllp_valid = 1; dllp_type = 2'(t); dllp_seq = 12'(s);
        step();
        dllp_valid = 0;
    endtask

    task automatic wait_act(input int want, input int budget, input string tag);
        int hit = 0;
        for (int i = 0; i < budget && hit == 0; i++) begin
            step();
            if (s_act == want) hit = 1;
        end
        check(tag, hit, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int hit;
        int wexp[4];
        wexp = '{4094, 4095, 0, 1};

        quiet();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        step();
        check("rst_seq", s_seq, 0);
        check("rst_ps", s_ps, 4095);
        check("rst_act", s_act, 0);
        check("rst_full", s_full, 0);
        rst = 0;

        // 1: grants 0..4, ACK 2 purges
        tlp_req = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t1_gnt", s_gnt, 1);
            check("t1_seq", s_seq, i);
        end
        tlp_req = 0;
        send_dllp(1, 2);
        step();
        check("t1_pv", s_pv, 1);
        check("t1_ps", s_ps, 2);
        step();
        check("t1_pv_pulse", s_pv, 0);

        // 2: fill to DEPTH
        do_reset();
        send_tlps(16);
        tlp_req = 1;
        step();
        tlp_req = 0;
        check("t2_gnt17", s_gnt, 0);
        check("t2_full", s_full, 1);
        send_dllp(1, 15);
        step();
        check("t2_notfull", s_full, 0);

        // 3: NAK replay, then stall mid-replay
        do_reset();
        send_tlps(4);
        send_dllp(2, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_rd_en) q.push_back(s_rd_idx);
        end
        check("t3_nreads", q.size(), 2);
        if (q.size() == 2) begin
            check("t3_rd0", q[0], 2);
            check("t3_rd1", q[1], 3);
        end
        check("t3_rn", s_rn, 1);
        check("t3_idle", s_act, 0);
        send_dllp(2, 1);
        hit = 0;
        for (int i = 0; i < 6 && hit == 0; i++) begin
            step();
            if (s_rd_en) hit = 1;
        end
        check("t3_rd_seen", hit, 1);
        check("t3_rd_first", s_rd_idx, 2);
        check("t3_rn2", s_rn, 2);
        buf_ready = 0;
        repeat (3) begin
            step();
            check("t3_hold_en", s_rd_en, 0);
            check("t3_hold_idx", s_rd_idx, 3);
        end
        buf_ready = 1;
        step();
        check("t3_resume", s_rd_en, 1);
        check("t3_resume_idx", s_rd_idx, 3);
        step();
        check("t3_back_idle", s_act, 0);

        // 4: timeouts escalate to retrain
        do_reset();
        send_tlps(1);
        for (int k = 0; k < 3; k++) begin
            wait_act(1, TMO + 50, "t4_timeout");
            check("t4_rn", s_rn, k + 1);
            check("t4_rd_idx", s_rd_idx, 0);
            wait_act(0, 10, "t4_done");
        end
        wait_act(1, TMO + 50, "t4_timeout4");
        check("t4_retrain_req", s_rr, 1);
        check("t4_rn_zero", s_rn, 0);
        retrain_done = 1;
        step();
        retrain_done = 0;
        step();
        check("t4_rn_after", s_rn, 1);
        check("t4_rd_en", s_rd_en, 1);
        check("t4_rd_idx2", s_rd_idx, 0);
        wait_act(0, 10, "t4_final");

        // 5: sequence wrap, stale ACK
        do_reset();
        for (int i = 0; i < 5000 && m_nts != 4094; i++) begin
            tlp_req = 1;
            dllp_valid = m_nts != 0;
            dllp_type = 2'b01;
            dllp_seq = 12'(wrap(m_nts - 1));
            step();
        end
        quiet();
        send_dllp(1, 4093);
        step();
        tlp_req = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_seq", s_seq, wexp[i]);
        end
        tlp_req = 0;
        send_dllp(1, 0);
        step();
        check("t5_pv", s_pv, 1);
        check("t5_ps", s_ps, 0);
        send_dllp(1, 4000);
        step();
        check("t5_stale_pv", s_pv, 0);
        check("t5_stale_ps", s_ps, 0);

        // 6: reset during replay
        do_reset();
        send_tlps(4);
        buf_ready = 0;
        send_dllp(2, 0);
        wait_act(1, 10, "t6_active");
        step();
        buf_ready = 1;
        rst = 1;
        step();
        rst = 0;
        step();
        check("t6_rd_en", s_rd_en, 0);
        check("t6_act", s_act, 0);
        check("t6_seq", s_seq, 0);
        check("t6_ps", s_ps, 4095);

        // random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int r;
            rst = ($urandom % 1000) == 0;
            tlp_req = ($urandom % 10) < 6;
            buf_ready = ($urandom % 4) != 0;
            retrain_done = ($urandom % 5) == 0;
            dllp_valid = ($urandom % 4) == 0;
            r = $urandom % 20;
            dllp_type = r < 9 ? 2'b01 : r < 17 ? 2'b10 : 2'(r & 1 ? 3 : 0);
            if (($urandom % 5) != 0)
                dllp_seq = 12'(wrap(m_ackd + $urandom_range(0, m_out())));
            else
                dllp_seq = 12'($urandom % 4096);
            step();
        end
        quiet();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/replay_scheduler.md
Name: replay_scheduler

Overview:
- Sequencing controller for the data-link replay buffer.
- Assigns transmit sequence numbers and grants new TLPs into the buffer.
- Processes ACK/NAK DLLPs, issues purge commands, and drives replay reads on NAK or replay-timer expiry.
- Counts replay attempts and requests link retrain on REPLAY_NUM rollover. Sits between the DLLP receive path, the TLP source, and the replay buffer read/write ports.

Parameters:
- SEQ_W, 12, sequence number width; all sequence arithmetic is modulo 2^SEQ_W.
- DEPTH, 16, maximum outstanding (unacknowledged) TLPs the buffer holds.
- TIMEOUT, 1024, replay timer expiry in clk cycles.
- TMR_W, 11, replay timer counter width; must satisfy 2^TMR_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tlp_req  in  1  TLP source requests to send a new TLP.
- tlp_gnt  out  1  new TLP accepted this cycle.
- tlp_seq  out  SEQ_W  sequence number assigned to the granted TLP.
- dllp_valid  in  1  ACK/NAK DLLP present.
- dllp_type  in  2  2'b01 = ACK, 2'b10 = NAK; other codes are ignored.
- dllp_seq  in  SEQ_W  AckNak_Seq_Num.
- buf_ready  in  1  replay buffer can accept a read (busy_n).
- rd_en  out  1  replay read strobe.
- rd_idx  out  SEQ_W  sequence number being replayed.
- purge_valid  out  1  one-cycle pulse: free entries up to and including purge_seq.
- purge_seq  out  SEQ_W  new ACKD_SEQ.
- replay_active  out  1  high in the REPLAY and RETRAIN states.
- replay_num  out  2  current REPLAY_NUM.
- retrain_req  out  1  one-cycle pulse on REPLAY_NUM rollover.
- retrain_done  in  1  link retrain complete.
- full  out  1  outstanding count == DEPTH.

Behaviour:
- Reset values:
  - Outputs: tlp_gnt 0, tlp_seq 0, rd_en 0, rd_idx 0, purge_valid 0, purge_seq all-ones, replay_active 0, replay_num 0, retrain_req 0, full 0.
  - Internal: NTS = 0, ACKD_SEQ = all-ones, timer 0, no pending replay, state IDLE.
- Outstanding count: OUT = (NTS - ACKD_SEQ - 1) mod 2^SEQ_W. full = (OUT == DEPTH).
- Grant (combinational): tlp_gnt = tlp_req & ~full & state==IDLE & ~replay_pending. tlp_seq = NTS. NTS increments on grant and wraps 4095 -> 0.
- DLLPs are registered. The ACK/NAK effect appears one cycle after dllp_valid.
- Validity check: d = (dllp_seq - ACKD_SEQ) mod 2^SEQ_W.
  - Valid if d <= OUT.
  - Otherwise the DLLP is ignored entirely, with no state change.
- Forward progress (valid ACK or NAK with d > 0):
  - ACKD_SEQ <= dllp_seq.
  - purge_valid pulses with purge_seq = dllp_seq.
  - replay_num <= 0.
  - Timer cleared.
- NAK, valid with any d (including 0): after any purge, replay_pending is set.
- Timer:
  - Counts while OUT > 0 and state == IDLE; held during REPLAY and RETRAIN.
  - Cleared when OUT == 0.
  - On reaching TIMEOUT it sets replay_pending and clears.
- State machine:
  - IDLE: if replay_pending && OUT > 0:
    - If replay_num == 3: go to RETRAIN, pulse retrain_req, replay_num <= 0.
    - Else: go to REPLAY, replay_num += 1, rd_idx <= ACKD_SEQ + 1.
    - replay_pending is cleared on leaving IDLE.
  - IDLE with replay_pending && OUT == 0: clear replay_pending, stay in IDLE.
  - REPLAY:
    - rd_en = buf_ready. Each read advances rd_idx by 1.
    - After the read of NTS-1, return to IDLE.
    - A forward-progress ACK during REPLAY moves rd_idx to max(rd_idx, ACKD_SEQ+1) in modular order.
    - If that leaves nothing to replay, return to IDLE immediately.
  - RETRAIN: waits for retrain_done, then enters REPLAY (replay_num becomes 1).
- Simultaneous events:
  - tlp_gnt and a purge in the same cycle both apply; OUT is updated from both.
  - A NAK during REPLAY or RETRAIN is latched into replay_pending and serviced on return to IDLE.
  - Timer expiry and a NAK in the same cycle cause a single replay_pending.
- rst mid-operation: all state returns to reset values next cycle; in-flight replay is abandoned.

Decomposition:
- Package replay_pkg:
  - SEQ_W.
  - DLLP type codes ACK = 2'b01, NAK = 2'b10.
  - State enum IDLE/REPLAY/RETRAIN.
  - Function seq_diff(a, b) returning modulo difference.
- Sub-module replay_timer:
  - Counter with clear, hold and enable inputs.
  - expire pulse output.

Test Plan:
1. Reset, then 5 tlp_req cycles -> tlp_gnt each cycle, tlp_seq 0..4. ACK seq 2 -> purge_valid one cycle later with purge_seq 2, OUT = 2.
2. Grant 16 TLPs -> full = 1 and tlp_gnt = 0 on the 17th request. ACK seq 15 -> full = 0 next cycle.
3. Send seq 0..3, then NAK seq 1 -> purge_seq 1, replay_num 1, rd_en/rd_idx 2 then 3, back to IDLE. With buf_ready low 3 cycles mid-replay -> rd_idx holds.
4. Send 1 TLP, no ACK -> replay_pending after TIMEOUT cycles, rd_idx 0. Repeat 3 more timeouts -> 4th triggers retrain_req pulse. retrain_done -> replay resumes, replay_num = 1.
5. NTS preloaded near wrap (4094), send 4 TLPs -> tlp_seq 4094, 4095, 0, 1. ACK seq 0 -> purge_seq 0. Stale ACK seq 4000 -> ignored.
6. Assert rst mid-REPLAY -> next cycle rd_en 0, replay_active 0, NTS 0, purge_seq 4095.
